// File: rtl/aud_pkg.sv
// Shared audio datapath definitions, used by both the recorder and the player.
// Holds the serialiser state encoding, default geometry and a saturating
// 8-bit increment used by the event counters.
package aud_pkg;

  localparam int SAMPLE_W_DEF   = 16;
  localparam int FIFO_DEPTH_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_ARM   = 3'd2,
    S_SHIFT = 3'd3,
    S_TAIL  = 3'd4
  } aud_state_e;

  // Increment that sticks at 8'hFF instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/aud_player_if.sv
// Upstream sample handshake between the playback/DSP stage and aud_player.
//   sample : sample word (SAMPLE_W bits), qualified by valid
//   valid  : sample is offered this cycle
//   ready  : consumer can take a sample this cycle
// master = sample producer, slave = aud_player.
interface aud_player_if #(
  parameter int SAMPLE_W = 16
);

  logic [SAMPLE_W-1:0] sample;
  logic                valid;
  logic                ready;

  modport master (output sample, output valid, input ready);
  modport slave  (input sample, input valid, output ready);

endinterface

// File: rtl/aud_fifo.sv
// Small synchronous sample FIFO clocked on the falling edge.
//   clk/rst_n : falling-edge clock, asynchronous active-low reset
//   push/din  : write din at the tail (ignored when full)
//   pop/dout  : dout shows the head; pop advances it (ignored when empty)
//   count     : registered occupancy
//   full/empty: registered flags, consistent with count
// DEPTH must be a power of two so the pointers wrap naturally.
module aud_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push && !full_r;
  assign pop_ok_s  = pop && !empty_r;

  // Next occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CW'(1'b1);
      2'b01:   count_nxt_s = count_r - CW'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Sample storage; contents need no reset since the flags gate every read.
  always_ff @(negedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and flags.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == {CW{1'b0}});
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/aud_player.sv
// Playback serialiser: buffers upstream samples and shifts one sample per
// LRC frame onto the DAC data line, LSB first, during the right (lrc=1) slot.
//   i_clk          : codec BCLK, all state changes on its falling edge
//   i_rst_n        : asynchronous active-low reset
//   i_lrc          : codec DACLRCK, high = active playback slot
//   i_en           : play enable (level)
//   ups            : sample/valid/ready handshake from upstream
//   o_dacdat       : registered serial DAC data
//   o_busy         : serialiser not idle
//   o_underrun     : one-cycle pulse when a slot starts with no sample queued
//   o_underrun_cnt : saturating underrun count
module aud_player
  import aud_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_lrc,
  input  logic         i_en,
  aud_player_if.slave  ups,
  output logic         o_dacdat,
  output logic         o_busy,
  output logic         o_underrun,
  output logic [7:0]   o_underrun_cnt
);

  localparam int CNT_W = $clog2(SAMPLE_W);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);
  localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

  aud_state_e          state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [SAMPLE_W-1:0] shreg_r;
  logic                dacdat_r;
  logic                underrun_r;
  logic [7:0]          ucnt_r;

  logic                push_s;
  logic                pop_s;
  logic [SAMPLE_W-1:0] head_s;
  logic [SAMPLE_W-1:0] load_s;
  logic [CW-1:0]       count_s;
  logic                full_s;
  logic                empty_s;

  // Pushing is independent of the serialiser state, including idle.
  assign push_s = ups.valid && !full_s;
  // Emptiness is the registered flag, so a push on the same edge is not seen.
  assign pop_s  = (state_r == S_ARM) && i_lrc && !empty_s;
  assign load_s = empty_s ? {SAMPLE_W{1'b0}} : head_s;

  aud_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push_s),
    .din   (ups.sample),
    .pop   (pop_s),
    .dout  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Frame sequencer and shifter. Once a slot has started the sample always
  // runs to completion; i_en is only honoured between samples.
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= S_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      shreg_r    <= {SAMPLE_W{1'b0}};
      dacdat_r   <= 1'b0;
      underrun_r <= 1'b0;
      ucnt_r     <= 8'd0;
    end else begin
      underrun_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          dacdat_r <= 1'b0;
          if (i_en) begin
            state_r <= S_SYNC;
          end
        end
        // Wait for the left half so playback never starts mid-slot.
        S_SYNC: begin
          dacdat_r <= 1'b0;
          if (!i_en) begin
            state_r <= S_IDLE;
          end else if (!i_lrc) begin
            state_r <= S_ARM;
          end
        end
        S_ARM: begin
          if (i_lrc) begin
            shreg_r  <= load_s;
            dacdat_r <= load_s[0];
            cnt_r    <= CNT_ONE;
            state_r  <= S_SHIFT;
            if (empty_s) begin
              underrun_r <= 1'b1;
              ucnt_r     <= sat_inc8(ucnt_r);
            end
          end else begin
            dacdat_r <= 1'b0;
            if (!i_en) begin
              state_r <= S_IDLE;
            end
          end
        end
        S_SHIFT: begin
          dacdat_r <= shreg_r[cnt_r];
          cnt_r    <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_BIT) begin
            state_r <= S_TAIL;
          end
        end
        // A short right slot has already dropped lrc, so this exits at once.
        S_TAIL: begin
          dacdat_r <= 1'b0;
          if (!i_lrc) begin
            state_r <= i_en ? S_ARM : S_IDLE;
          end
        end
        default: begin
          state_r  <= S_IDLE;
          dacdat_r <= 1'b0;
        end
      endcase
    end
  end

  assign ups.ready      = (count_s < DEPTH_C);
  assign o_dacdat       = dacdat_r;
  assign o_busy         = (state_r != S_IDLE);
  assign o_underrun     = underrun_r;
  assign o_underrun_cnt = ucnt_r;

endmodule

// File: tb/tb_aud_player.sv
// Self-checking bench for aud_player: a directed vector table for the first
// frame, hand-written multi-frame sequences, randomized traffic, and an
// abstract frame/queue model checked on every BCLK period.
module tb_aud_player;

  localparam int FIFO_D = 2;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_lrc;
  logic       i_en;
  logic       o_dacdat;
  logic       o_busy;
  logic       o_underrun;
  logic [7:0] o_underrun_cnt;

  aud_player_if #(.SAMPLE_W(16)) pif ();

  aud_player #(.SAMPLE_W(16), .FIFO_DEPTH(FIFO_D)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_lrc          (i_lrc),
    .i_en           (i_en),
    .ups            (pif),
    .o_dacdat       (o_dacdat),
    .o_busy         (o_busy),
    .o_underrun     (o_underrun),
    .o_underrun_cnt (o_underrun_cnt)
  );

  initial i_clk = 1'b1;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        lrc;
    logic        en;
    logic        valid;
    logic [15:0] sample;
    logic        exp_dacdat;
    logic        exp_underrun;
    logic        exp_busy;
  } vec_t;

  vec_t tv[48];
  int   exp_seq[16] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};

  int          checks = 0;
  int          errors = 0;
  int          phase  = 0;
  int          und_seen;
  int          ones_cnt;
  logic [15:0] cap;
  logic [15:0] last_frame;

  // Reference model: queued samples plus a description of where playback is.
  logic [15:0] mq[$];
  logic        m_engaged;   // player switched on
  logic        m_gap;       // left half seen, next right half starts a sample
  int          m_bit;       // next bit to emit (1..15), 16 = sample done, -1 none
  logic [15:0] m_cur;
  logic        m_out;
  logic        m_und;
  int          m_ucnt;
  logic        m_push;

  task automatic model_reset();
    mq.delete();
    m_engaged = 1'b0;
    m_gap     = 1'b0;
    m_bit     = -1;
    m_cur     = 16'h0000;
    m_out     = 1'b0;
    m_und     = 1'b0;
    m_ucnt    = 0;
    m_push    = 1'b0;
  endtask

  task automatic model_edge(input logic lrc, input logic en, input logic valid,
                            input logic [15:0] smp);
    logic push;
    push  = valid && (mq.size() < FIFO_D);
    m_out = 1'b0;
    m_und = 1'b0;
    if (!m_engaged) begin
      if (en) begin
        m_engaged = 1'b1;
        m_gap     = 1'b0;
        m_bit     = -1;
      end
    end else if (m_bit >= 1 && m_bit <= 15) begin
      m_out = m_cur[m_bit];
      m_bit = m_bit + 1;
    end else if (m_bit == 16) begin
      if (!lrc) begin
        m_bit = -1;
        m_gap = 1'b1;
        if (!en) m_engaged = 1'b0;
      end
    end else if (!m_gap) begin
      if (!en) m_engaged = 1'b0;
      else if (!lrc) m_gap = 1'b1;
    end else begin
      if (lrc) begin
        if (mq.size() == 0) begin
          m_cur = 16'h0000;
          m_und = 1'b1;
          if (m_ucnt < 255) m_ucnt = m_ucnt + 1;
        end else begin
          m_cur = mq.pop_front();
        end
        m_out = m_cur[0];
        m_bit = 1;
      end else if (!en) begin
        m_engaged = 1'b0;
      end
    end
    if (push) mq.push_back(smp);
    m_push = push;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (phase %0d, t=%0t)", name, act, exp, phase, $time);
    end
  endtask

  function automatic logic lrc_of(input int p);
    return (p % 32) >= 16;
  endfunction

  // One BCLK period: drive inputs, step the model, let the falling edge
  // happen, then check all outputs on the following rising edge.
  task automatic cyc(input logic lrc, input logic en, input logic valid,
                     input logic [15:0] smp);
    i_lrc      = lrc;
    i_en       = en;
    pif.valid  = valid;
    pif.sample = smp;
    model_edge(lrc, en, valid, smp);
    @(negedge i_clk);
    @(posedge i_clk);
    chk("dacdat", 32'(o_dacdat), 32'(m_out));
    chk("busy", 32'(o_busy), 32'(m_engaged));
    chk("ready", 32'(pif.ready), 32'(mq.size() < FIFO_D));
    chk("underrun", 32'(o_underrun), 32'(m_und));
    chk("underrun_cnt", 32'(o_underrun_cnt), 32'(m_ucnt));
    if (o_underrun) und_seen = und_seen + 1;
    if (o_dacdat)   ones_cnt = ones_cnt + 1;
    if ((phase % 32) >= 16) cap[(phase % 32) - 16] = o_dacdat;
    if ((phase % 32) == 31) last_frame = cap;
    phase = phase + 1;
  endtask

  task automatic run_until(input int target, input logic en, input logic valid,
                           input logic [15:0] smp);
    while (phase < target) cyc(lrc_of(phase), en, valid, smp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dacdat"}, 32'(o_dacdat), 32'd0);
    chk({tag, "_ready"}, 32'(pif.ready), 32'd1);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_underrun"}, 32'(o_underrun), 32'd0);
    chk({tag, "_underrun_cnt"}, 32'(o_underrun_cnt), 32'd0);
  endtask

  initial begin
    logic [15:0] s[3];
    int          acc_phase[3];
    int          guard;
    logic        ren;
    int          base;
    logic [15:0] x_smp;
    logic [15:0] y_smp;

    // Directed first-frame table: 48 periods, lrc high for periods 16..31.
    for (int i = 0; i < 48; i++) begin
      tv[i].lrc          = lrc_of(i);
      tv[i].en           = 1'b1;
      tv[i].valid        = (i == 0);
      tv[i].sample       = 16'hA5C3;
      tv[i].exp_dacdat   = (i >= 16 && i < 32) ? exp_seq[i - 16][0] : 1'b0;
      tv[i].exp_underrun = 1'b0;
      tv[i].exp_busy     = 1'b1;
    end

    i_rst_n    = 1'b0;
    i_lrc      = 1'b0;
    i_en       = 1'b0;
    pif.valid  = 1'b0;
    pif.sample = 16'h0000;
    und_seen   = 0;
    ones_cnt   = 0;
    cap        = 16'h0000;
    last_frame = 16'h0000;
    model_reset();
    #1;
    chk_reset_outputs("rst");
    @(negedge i_clk); @(posedge i_clk);
    @(negedge i_clk); @(posedge i_clk);
    i_rst_n = 1'b1;
    phase   = 0;

    // First sample 16'hA5C3 played LSB first in the first right slot.
    for (int i = 0; i < 48; i++) begin
      cyc(tv[i].lrc, tv[i].en, tv[i].valid, tv[i].sample);
      chk("tbl_dacdat", 32'(o_dacdat), 32'(tv[i].exp_dacdat));
      chk("tbl_underrun", 32'(o_underrun), 32'(tv[i].exp_underrun));
      chk("tbl_busy", 32'(o_busy), 32'(tv[i].exp_busy));
    end
    chk("a5c3_frame", 32'(last_frame), 32'h0000A5C3);

    // Three empty slots: 48 zero bits, three underrun pulses.
    und_seen = 0;
    ones_cnt = 0;
    run_until(140, 1'b1, 1'b0, 16'h0000);
    chk("und_pulses", und_seen, 32'd3);
    chk("und_cnt3", 32'(o_underrun_cnt), 32'd3);
    chk("und_zero_bits", ones_cnt, 32'd0);
    cyc(lrc_of(phase), 1'b1, 1'b1, 16'h0001);
    run_until(176, 1'b1, 1'b0, 16'h0000);
    chk("one_frame", 32'(last_frame), 32'h00000001);
    chk("und_cnt_hold", 32'(o_underrun_cnt), 32'd3);

    // Back-to-back pushes with valid held: third waits for the first pop.
    run_until(192, 1'b1, 1'b0, 16'h0000);
    for (int k = 0; k < 3; k++) s[k] = 16'($urandom);
    for (int k = 0; k < 3; k++) begin
      guard = 0;
      m_push = 1'b0;
      while (!m_push && guard < 64) begin
        cyc(lrc_of(phase), 1'b1, 1'b1, s[k]);
        guard = guard + 1;
      end
      if (!m_push) chk("push_timeout", 32'd0, 32'd1);
      acc_phase[k] = phase - 1;
      if (k == 1) chk("ready_full", 32'(pif.ready), 32'd0);
    end
    chk("acc0", acc_phase[0], 32'd192);
    chk("acc1", acc_phase[1], 32'd193);
    chk("acc2_after_pop", acc_phase[2], 32'd209);
    run_until(224, 1'b1, 1'b0, 16'h0000);
    chk("order0", 32'(last_frame), 32'(s[0]));
    run_until(256, 1'b1, 1'b0, 16'h0000);
    chk("order1", 32'(last_frame), 32'(s[1]));
    run_until(288, 1'b1, 1'b0, 16'h0000);
    chk("order2", 32'(last_frame), 32'(s[2]));

    // Enable dropped after bit 5 of 16'hFFFF: sample completes, then idle.
    x_smp = 16'h1234 ^ 16'($urandom_range(16'hFFFF));
    y_smp = 16'h8001;
    run_until(290, 1'b1, 1'b0, 16'h0000);
    cyc(lrc_of(phase), 1'b1, 1'b1, 16'hFFFF);
    cyc(lrc_of(phase), 1'b1, 1'b1, x_smp);
    run_until(310, 1'b1, 1'b0, 16'h0000);
    run_until(336, 1'b0, 1'b0, 16'h0000);
    chk("ffff_frame", 32'(last_frame), 32'h0000FFFF);
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_ready_one_left", 32'(pif.ready), 32'd1);
    cyc(lrc_of(phase), 1'b0, 1'b1, y_smp);
    chk("idle_push_fills", 32'(pif.ready), 32'd0);

    // Enable raised inside a right slot: waits for the next full slot.
    run_until(340, 1'b0, 1'b0, 16'h0000);
    ones_cnt = 0;
    run_until(368, 1'b1, 1'b0, 16'h0000);
    chk("sync_silent", ones_cnt, 32'd0);
    run_until(384, 1'b1, 1'b0, 16'h0000);
    chk("sync_frame", 32'(last_frame), 32'(x_smp));
    run_until(416, 1'b1, 1'b0, 16'h0000);
    chk("sync_next", 32'(last_frame), 32'(y_smp));

    // Randomized traffic against the model.
    ren = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(63) == 0) ren = ~ren;
      cyc(lrc_of(phase), ren, 1'($urandom_range(1)), 16'($urandom));
    end

    // Long run of empty slots: counter saturates.
    run_until(phase + 300 * 32, 1'b1, 1'b0, 16'h0000);
    chk("und_sat", 32'(o_underrun_cnt), 32'd255);

    // Asynchronous reset while shifting discards everything at once.
    base = (phase / 32 + 1) * 32;
    run_until(base, 1'b1, 1'b0, 16'h0000);
    cyc(lrc_of(phase), 1'b1, 1'b1, 16'hBEEF);
    cyc(lrc_of(phase), 1'b1, 1'b1, 16'h7777);
    run_until(base + 21, 1'b1, 1'b0, 16'h0000);
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    @(negedge i_clk);
    @(posedge i_clk);
    i_rst_n = 1'b1;
    phase   = phase + 1;
    chk_reset_outputs("postrst");
    run_until(base + 64, 1'b1, 1'b0, 16'h0000);
    chk("postrst_frame", 32'(last_frame), 32'd0);
    chk("postrst_und", 32'(o_underrun_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
